// File: rtl/fsm_seq_pkg.sv
// Shared state encodings and 7-segment codes for the start/count/done sequencer.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LED_IDLE  = 8'd10;
  localparam logic [7:0] LED_COUNT = 8'd5;
  localparam logic [7:0] LED_PAUSE = 8'd7;
  localparam logic [7:0] LED_DONE  = 8'd15;

endpackage

// File: rtl/fsm_seq_prescaler.sv
// Free-running clock divider: counts while run is high, holds otherwise, and
// raises tick for the one cycle whose edge wraps it back to zero.
module fsm_seq_prescaler #(
  parameter int PRESCALE_MAX = 10_000_000,
  parameter int PRESCALE_W   = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] WRAP = PRESCALE_W'(PRESCALE_MAX - 1);

  logic [PRESCALE_W-1:0] pre;

  assign tick = run & ~clear & (pre == WRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (run) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_seq_timer.sv
// Start/count/done sequencer with run-time target, prescaled tick, abort and
// auto-repeat. Pause support is built only when FSM_SEQ_PAUSE_EN is defined.
//
// state | meaning
// IDLE  | waiting for ena & start; count shows the last result
// COUNT | prescaler running, count advances on each tick
// PAUSE | prescaler and count frozen while pause is high
// DONE  | one-cycle completion, count == target_q
module fsm_seq_timer
  import fsm_seq_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int PRESCALE_MAX = 10_000_000,
  parameter int PRESCALE_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             auto_repeat,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state_out,
  output logic [7:0]       led_out,
  output logic             done,
  output logic             busy
);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic [CNT_W-1:0] target_q, target_nxt;
  logic [CNT_W-1:0] count_inc;
  logic             pause_eff;
  logic             run;
  logic             clear;
  logic             tick;

`ifdef FSM_SEQ_PAUSE_EN
  assign pause_eff = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_eff    = 1'b0;
`endif

  assign count_inc = count_q + 1'b1;

  // A PAUSE cycle with pause already released advances like COUNT, so each
  // paused cycle costs exactly one cycle of latency.
  assign run   = ena & ~abort & ~pause_eff & busy & (target_q != '0);
  assign clear = ~ena | abort | ~busy;

  fsm_seq_prescaler #(
    .PRESCALE_MAX (PRESCALE_MAX),
    .PRESCALE_W   (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_nxt;
      count_q  <= count_nxt;
      target_q <= target_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    target_nxt = target_q;
    if (!ena || abort) begin
      state_nxt = ST_IDLE;
      if (state_q != ST_IDLE) count_nxt = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_nxt  = ST_COUNT;
            target_nxt = target;
            count_nxt  = '0;
          end
        end
`ifdef FSM_SEQ_PAUSE_EN
        ST_COUNT, ST_PAUSE: begin
`else
        ST_COUNT: begin
`endif
          if (pause_eff) begin
            state_nxt = ST_PAUSE;
          end else if (target_q == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_COUNT;
            if (tick) begin
              count_nxt = count_inc;
              if (count_inc == target_q) state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (auto_repeat) begin
            state_nxt  = ST_COUNT;
            target_nxt = target;
            count_nxt  = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    state_out = ST_IDLE;
    led_out   = LED_IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_COUNT: begin
        state_out = ST_COUNT;
        led_out   = LED_COUNT;
        busy      = 1'b1;
      end
`ifdef FSM_SEQ_PAUSE_EN
      ST_PAUSE: begin
        state_out = ST_PAUSE;
        led_out   = LED_PAUSE;
        busy      = 1'b1;
      end
`endif
      ST_DONE: begin
        state_out = ST_DONE;
        led_out   = LED_DONE;
        done      = 1'b1;
      end
      default: begin
        state_out = ST_IDLE;
        led_out   = LED_IDLE;
      end
    endcase
  end

  assign count = count_q;

endmodule
